// File: rtl/ifetch_loader_pkg.sv
// ifetch_loader_pkg: shared memory geometry and FSM encoding for the
// instruction-fetch front end.
//   MEM_WIDTH : instruction / IMEM port width
//   MEM_DEPTH : IMEM words (program space 0..MEM_DEPTH-1)
//   MEM_AW    : word-address width used for pointers and PCs
package ifetch_loader_pkg;

    localparam int MEM_WIDTH = 32;
    localparam int MEM_DEPTH = 64;
    localparam int MEM_AW    = $clog2(MEM_DEPTH);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/ifetch_pc.sv
// ifetch_pc: fetch PC generator.
//   clk, rst_n      : clock, async active-low reset
//   clear_i         : restart point (entering RUN, or abandoning RUN); pc=0, f_valid=0
//   run_i           : fetching enabled
//   stall_i         : hold the word currently presented to decode
//   br_taken_i      : redirect to br_target_i (beats stall_i)
//   br_target_i     : redirect word address
//   fetch_addr_o    : address presented to IMEM this cycle
//   f_pc_o          : address of the word IMEM returns this cycle
//   f_valid_o       : f_pc_o is a real fetch
module ifetch_pc #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic          run_i,
    input  logic          stall_i,
    input  logic          br_taken_i,
    input  logic [AW-1:0] br_target_i,
    output logic [AW-1:0] fetch_addr_o,
    output logic [AW-1:0] f_pc_o,
    output logic          f_valid_o
);

    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] f_pc_q, f_pc_d;
    logic          f_valid_q, f_valid_d;

    // Wrap explicitly so non-power-of-two depths still stay in program space.
    function automatic logic [AW-1:0] inc_wrap(input logic [AW-1:0] x);
        return (x == AW'(DEPTH - 1)) ? '0 : x + AW'(1);
    endfunction

    always_comb begin
        pc_d         = pc_q;
        f_pc_d       = f_pc_q;
        f_valid_d    = f_valid_q;
        fetch_addr_o = pc_q;
        if (clear_i) begin
            pc_d      = '0;
            f_valid_d = 1'b0;
        end else if (run_i) begin
            if (br_taken_i) begin
                // Fetch the target this very cycle: zero-bubble redirect.
                fetch_addr_o = br_target_i;
                f_pc_d       = br_target_i;
                pc_d         = inc_wrap(br_target_i);
                f_valid_d    = 1'b1;
            end else if (stall_i) begin
                // Re-read the held word so IMEM's registered output stays put.
                fetch_addr_o = f_pc_q;
            end else begin
                f_pc_d    = pc_q;
                pc_d      = inc_wrap(pc_q);
                f_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= '0;
            f_pc_q    <= '0;
            f_valid_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            f_pc_q    <= f_pc_d;
            f_valid_q <= f_valid_d;
        end
    end

    assign f_pc_o    = f_pc_q;
    assign f_valid_o = f_valid_q;

endmodule

// File: rtl/ifetch_loader.sv
// ifetch_loader: IMEM front end. Boot-loads a program over ld_valid/ld_ready,
// then fetches one word per cycle with stall and branch redirect.
//   clk, rst_n                       : clock, async active-low reset
//   ld_valid/ld_ready/ld_data/ld_last: program load stream (LOAD state)
//   start_load                       : abandon RUN and reload
//   imem_addr/imem_wre/imem_wr_data  : IMEM port (driven by loader or fetcher)
//   imem_rd_data                     : IMEM registered read data
//   stall, br_taken, br_target       : decode back-pressure / redirect
//   instr, instr_pc, instr_valid     : fetched word to decode
//   load_done                        : high in RUN
module ifetch_loader
    import ifetch_loader_pkg::*;
#(
    parameter int WIDTH = MEM_WIDTH,
    parameter int DEPTH = MEM_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             ld_last,
    input  logic             start_load,
    output logic [WIDTH-1:0] imem_addr,
    output logic             imem_wre,
    output logic [WIDTH-1:0] imem_wr_data,
    input  logic [WIDTH-1:0] imem_rd_data,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic             instr_valid,
    output logic             load_done
);

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          pc_clear;
    logic          run;
    logic [AW-1:0] fetch_addr;
    logic [AW-1:0] f_pc;
    logic          f_valid;
    logic          unused_br_hi;

    assign run          = (state_q == ST_RUN);
    assign unused_br_hi = ^br_target[WIDTH-1:AW];

    ifetch_pc #(.DEPTH(DEPTH), .AW(AW)) u_pc (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (pc_clear),
        .run_i        (run),
        .stall_i      (stall),
        .br_taken_i   (br_taken),
        .br_target_i  (br_target[AW-1:0]),
        .fetch_addr_o (fetch_addr),
        .f_pc_o       (f_pc),
        .f_valid_o    (f_valid)
    );

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        pc_clear     = 1'b0;
        ld_ready     = 1'b0;
        imem_wre     = 1'b0;
        imem_wr_data = '0;
        imem_addr    = {{(WIDTH-AW){1'b0}}, fetch_addr};
        unique case (state_q)
            ST_LOAD: begin
                ld_ready     = 1'b1;
                imem_addr    = {{(WIDTH-AW){1'b0}}, wr_ptr_q};
                imem_wr_data = ld_data;
                imem_wre     = ld_valid;
                if (ld_valid) begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    // Leaving on the top word means nothing past DEPTH is accepted.
                    if (ld_last || wr_ptr_q == AW'(DEPTH - 1)) begin
                        state_d  = ST_RUN;
                        pc_clear = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (start_load) begin
                    state_d  = ST_LOAD;
                    wr_ptr_d = '0;
                    pc_clear = 1'b1;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_LOAD;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    assign instr       = imem_rd_data;
    assign instr_pc    = {{(WIDTH-AW){1'b0}}, f_pc};
    assign instr_valid = f_valid & run;
    assign load_done   = run;

endmodule

// File: tb/tb_ifetch_loader.sv
module tb_ifetch_loader;

    localparam int W = 32;
    localparam int D = 64;

    typedef struct {
        logic [W-1:0] pc;
        logic [W-1:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ld_valid = 1'b0;
    logic         ld_ready;
    logic [W-1:0] ld_data = '0;
    logic         ld_last = 1'b0;
    logic         start_load = 1'b0;
    logic [W-1:0] imem_addr;
    logic         imem_wre;
    logic [W-1:0] imem_wr_data;
    logic [W-1:0] imem_rd_data;
    logic         stall = 1'b0;
    logic         br_taken = 1'b0;
    logic [W-1:0] br_target = '0;
    logic [W-1:0] instr;
    logic [W-1:0] instr_pc;
    logic         instr_valid;
    logic         load_done;

    always #5 clk = ~clk;

    ifetch_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_data      (ld_data),
        .ld_last      (ld_last),
        .start_load   (start_load),
        .imem_addr    (imem_addr),
        .imem_wre     (imem_wre),
        .imem_wr_data (imem_wr_data),
        .imem_rd_data (imem_rd_data),
        .stall        (stall),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .load_done    (load_done)
    );

    // IMEM: synchronous write, registered read.
    logic [W-1:0] imem [D];
    always @(posedge clk) begin
        if (imem_wre) imem[imem_addr[5:0]] <= imem_wr_data;
        imem_rd_data <= imem[imem_addr[5:0]];
    end

    // Reference model state
    bit           m_run;
    bit           m_fv;
    logic [5:0]   m_wr;
    logic [5:0]   m_pc;
    logic [W-1:0] mem_exp [D];
    exp_t         q[$];
    int           n_cmp = 0;
    int           n_err = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_fetch(input logic [5:0] a);
        exp_t e;
        if (q.size() > 0) void'(q.pop_front());
        e.pc   = {{(W-6){1'b0}}, a};
        e.data = mem_exp[a];
        q.push_back(e);
        m_fv = 1'b1;
    endtask

    // One clock: drive at negedge, check the IMEM port, advance the model
    // across the posedge, then check decode-side outputs at the next negedge.
    task automatic cyc(input bit lv, input logic [W-1:0] ld, input bit last,
                       input bit sl, input bit st, input bit br, input logic [W-1:0] tgt);
        ld_valid = lv; ld_data = ld; ld_last = last;
        start_load = sl; stall = st; br_taken = br; br_target = tgt;
        #1;
        chk("ld_ready", {31'b0, ld_ready}, {31'b0, !m_run});
        chk("imem_wre", {31'b0, imem_wre}, {31'b0, (!m_run && lv)});
        if (!m_run && lv) begin
            chk("wr_addr", imem_addr, {26'b0, m_wr});
            chk("wr_data", imem_wr_data, ld);
        end
        if (!m_run) begin
            if (lv) begin
                mem_exp[m_wr] = ld;
                if (last || m_wr == 6'(D - 1)) begin
                    m_run = 1'b1; m_pc = '0; m_fv = 1'b0;
                end
                m_wr = m_wr + 6'd1;
            end
        end else if (sl) begin
            m_run = 1'b0; m_wr = '0; m_pc = '0; m_fv = 1'b0;
            q.delete();
        end else if (br) begin
            push_fetch(tgt[5:0]);
            m_pc = tgt[5:0] + 6'd1;
        end else if (!st) begin
            push_fetch(m_pc);
            m_pc = m_pc + 6'd1;
        end
        @(negedge clk);
        chk("load_done", {31'b0, load_done}, {31'b0, m_run});
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, (m_run && m_fv)});
        if (m_run && m_fv) begin
            if (q.size() == 0) begin
                chk("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                chk("instr_pc", instr_pc, q[0].pc);
                chk("instr", instr, q[0].data);
            end
        end
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) cyc(0, '0, 0, 0, 0, 0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < D; i++) begin
            imem[i] = '0;
            mem_exp[i] = '0;
        end
        m_run = 0; m_fv = 0; m_wr = '0; m_pc = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ld_ready", {31'b0, ld_ready}, 32'd1);
        chk("rst_imem_wre", {31'b0, imem_wre}, 32'd0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_load_done", {31'b0, load_done}, 32'd0);
        rst_n = 1'b1;

        // Load 0x11..0x15 with ld_valid toggling; ld_last on the fifth word
        for (int i = 0; i < 5; i++) begin
            cyc(1, W'(32'h11 + i), (i == 4), 0, 0, 0, '0);
            if (i != 4) cyc(0, 32'hdead, 0, 0, 0, 0, '0);
        end

        // Fetch 0,1,2 then stall 3 cycles on pc 2, resume
        run_n(3);
        chk("stall_pc", instr_pc, 32'd2);
        chk("stall_instr", instr, 32'h13);
        for (int i = 0; i < 3; i++) cyc(0, '0, 0, 0, 1, 0, '0);
        run_n(2);

        // Branch with stall asserted: branch wins, then sequential
        cyc(0, '0, 0, 0, 1, 1, 32'd1);
        chk("br_pc", instr_pc, 32'd1);
        chk("br_instr", instr, 32'h12);
        run_n(2);
        // Target with high bits set: only low AW bits used
        cyc(0, '0, 0, 0, 0, 1, 32'h0000_0043);
        run_n(2);

        // start_load in RUN, then a full DEPTH load without ld_last
        cyc(0, '0, 0, 1, 0, 0, '0);
        for (int i = 0; i < D; i++) cyc(1, $urandom, 0, 0, 0, 0, '0);
        chk("auto_run", {31'b0, load_done}, 32'd1);
        run_n(D + 4);

        // start_load, partial load, then asynchronous reset mid-LOAD
        cyc(0, '0, 0, 1, 0, 0, '0);
        cyc(1, 32'haaaa_0000, 0, 0, 0, 0, '0);
        cyc(1, 32'haaaa_0001, 0, 0, 0, 0, '0);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("arst_ld_ready", {31'b0, ld_ready}, 32'd1);
        chk("arst_wr_addr", imem_addr, 32'd0);
        m_run = 0; m_fv = 0; m_wr = '0; m_pc = '0; q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        // Single-word program; address 1 keeps its partially loaded value
        cyc(1, 32'hbeef_0000, 1, 0, 0, 0, '0);
        run_n(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ifetch_loader.md
Name: ifetch_loader

Overview:
Instruction-fetch front end that sits directly upstream of IMEM and drives its i_addr/wre/wr_data port.
- After reset it runs a boot-load phase that streams a program into IMEM over a valid/ready interface.
- It then switches to run phase: a PC generator that fetches one word per cycle, with stall and branch redirect.
- It presents fetched instructions to decode with their PC and a valid flag.

Parameters:
WIDTH, `width (mem_parameters), data/instruction and IMEM port width
DEPTH, 64, IMEM words; program space 0..DEPTH-1
AW, $clog2(DEPTH), internal pointer/PC width; all addresses are word addresses, increment 1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ld_valid  in  1  loader word valid
ld_ready  out  1  loader word accepted (LOAD state)
ld_data  in  WIDTH  instruction word to store
ld_last  in  1  marks final word of program
start_load  in  1  pulse: abandon run, reload program
imem_addr  out  WIDTH  to IMEM i_addr, zero-extended from AW
imem_wre  out  1  to IMEM wre
imem_wr_data  out  WIDTH  to IMEM wr_data
imem_rd_data  in  WIDTH  from IMEM i_data (registered read, 1-cycle latency)
stall  in  1  decode back-pressure: hold current instruction
br_taken  in  1  redirect fetch
br_target  in  WIDTH  redirect word address (low AW bits used)
instr  out  WIDTH  fetched instruction (= imem_rd_data)
instr_pc  out  WIDTH  word address of instr
instr_valid  out  1  instr/instr_pc meaningful
load_done  out  1  high in RUN state

Behaviour:
- States: LOAD, RUN.
- Async reset (rst_n=0): state=LOAD, wr_ptr=0, pc=0, f_pc=0, f_valid=0. Outputs: ld_ready=1, imem_wre=0 (no ld_valid), instr_valid=0, load_done=0.
- LOAD:
  - ld_ready=1; imem_addr=wr_ptr; imem_wr_data=ld_data; imem_wre=ld_valid (combinational).
  - On ld_valid at an edge: word written to wr_ptr, wr_ptr++.
  - If ld_last=1 or wr_ptr==DEPTH-1: next state RUN, pc=0, f_valid=0. Words beyond DEPTH are therefore never accepted.
  - ld_valid=0 cycles: no write, no pointer change.
  - start_load is ignored in LOAD. stall and br_taken are ignored in LOAD.
- RUN:
  - ld_ready=0, imem_wre=0; pc holds the next address to fetch.
  - Priority per cycle: start_load > br_taken > stall > normal.
  - Normal: imem_addr=pc; at edge f_pc<=pc, f_valid<=1, pc<=pc+1 (wraps DEPTH-1 -> 0).
  - stall: imem_addr=f_pc (re-read current word); pc, f_pc, f_valid unchanged; instr/instr_pc/instr_valid hold stable for every stalled cycle.
  - br_taken (overrides stall): imem_addr=br_target[AW-1:0]; at edge f_pc<=br_target, pc<=br_target+1 (wrapped), f_valid<=1. Zero-bubble redirect.
  - start_load: at edge state=LOAD, wr_ptr=0, f_valid=0, pc=0. instr_valid low from the next cycle.
- Outputs: instr=imem_rd_data, instr_pc=zero-extended f_pc, instr_valid=f_valid & (state==RUN).
- Latency:
  - First instr_valid occurs 2 cycles after the RUN entry edge (1 cycle addressing + 1 cycle IMEM).
  - Branch target instruction is valid 1 cycle after the br_taken edge.
- The last loaded word is written on the same edge RUN is entered; the first read of address 0 follows, so there is no hazard.
- Reset mid-LOAD or mid-RUN: immediate return to the reset state; the partially written IMEM contents are not cleared.

Decomposition:
- Shared package/header (mem_parameters): `width, DEPTH, AW, state encodings ST_LOAD/ST_RUN.
- One sub-module: ifetch_pc (pc, f_pc, f_valid registers plus the stall/branch/wrap next-PC mux).
- ifetch_loader keeps the FSM, wr_ptr and the IMEM port muxing.

Test Plan:
- Load 5 words 0x11..0x15, ld_last on 5th -> imem writes to addrs 0..4, load_done rises; instr_valid rises 2 cycles later with (pc,instr)=(0,0x11),(1,0x12)...
- ld_valid toggling 1,0,1,0 during load -> only valid cycles write; addresses contiguous 0,1,2; ld_ready constant 1.
- RUN, stall held 3 cycles while instr_pc=2 -> instr_pc=2, instr=0x13 stable 3 cycles; resumes with pc 3 next cycle.
- br_taken=1, br_target=1 together with stall=1 -> next cycle instr_pc=1, instr=0x12; then 2, 3 sequentially.
- Load DEPTH words without ld_last -> auto RUN after word DEPTH-1; run past DEPTH-1 -> instr_pc wraps to 0.
- start_load during RUN, then rst_n low mid-LOAD -> instr_valid drops next cycle; reset forces LOAD, wr_ptr=0, instr_valid=0 asynchronously.
